// File: rtl/memdata_arbiter.sv
// memdata_arbiter: two-port round-robin arbiter/sequencer for an external byte-wide data memory.
// Each transfer runs IDLE -> ACC -> DONE. The winning request is latched in IDLE. ACC drives the
// memory pins for one cycle, and DONE pulses the winner's ack.
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   req/we/dir/wdata 0 and 1      per-port request, direction (1 = write), address, write data
//   ack0/ack1, rdata0/rdata1      per-port one-cycle completion pulse and held read data
//   mem_cs/we/oe/dir/indata       memory control, address and write data
//   mem_outdata                   combinational memory read data
//   busy                          high while a transfer is in ACC or DONE
module memdata_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] dir0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] dir1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_cs,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [AW-1:0] mem_dir,
    output logic [DW-1:0] mem_indata,
    input  logic [DW-1:0] mem_outdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e        state_q, state_d;
    logic          last_q;
    logic          cmd_port_q;
    logic          cmd_we_q;
    logic [AW-1:0] cmd_dir_q;
    logic [DW-1:0] cmd_wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          grant;
    logic          launch;

    // On a tie the port that did not win last time is granted. With a single request,
    // req1 alone decides the winner.
    always_comb begin
        if (req0 && req1) begin
            grant = ~last_q;
        end else begin
            grant = req1;
        end
    end

    assign launch = (state_q == StIdle) && (req0 || req1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req0 || req1) state_d = StAcc;
            StAcc:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch, round-robin history and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_dir_q   <= '0;
            cmd_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            if (launch) begin
                last_q      <= grant;
                cmd_port_q  <= grant;
                cmd_we_q    <= grant ? we1 : we0;
                cmd_dir_q   <= grant ? dir1 : dir0;
                cmd_wdata_q <= grant ? wdata1 : wdata0;
            end
            if ((state_q == StAcc) && !cmd_we_q) begin
                if (cmd_port_q) begin
                    rdata1_q <= mem_outdata;
                end else begin
                    rdata0_q <= mem_outdata;
                end
            end
        end
    end

    // Outputs: only cs/we/oe are gated by state; address and write data always show the latch
    always_comb begin
        mem_cs = 1'b0;
        mem_we = 1'b0;
        mem_oe = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        busy   = 1'b0;
        unique case (state_q)
            StAcc: begin
                mem_cs = 1'b1;
                mem_we = cmd_we_q;
                mem_oe = ~cmd_we_q;
                busy   = 1'b1;
            end
            StDone: begin
                ack0 = ~cmd_port_q;
                ack1 = cmd_port_q;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_dir    = cmd_dir_q;
    assign mem_indata = cmd_wdata_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;

endmodule
